// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: it assembles a framed byte stream into 32-bit words,
// writes them to memory, verifies an XOR checksum, then releases the core and passes its fetch address through.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);
    localparam int CW = 11;
    localparam logic [CW-1:0] MAX_N = CW'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic              cpu_run_q, cpu_run_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              xfer;
    logic [CW-1:0]     hdr_n;

    assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign hdr_n      = {byte_data[2:0], cnt_lo_q};

    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        lane_d      = lane_q;
        wbuf_d      = wbuf_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        mem_wd_d    = mem_wd_q;
        cpu_run_d   = cpu_run_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;

        // A new load request wins over any byte presented on the same edge.
        if (load_req) begin
            state_d    = S_HDR0;
            cpu_run_d  = 1'b0;
            load_err_d = 1'b0;
            lane_d     = 2'd0;
            wcnt_d     = '0;
            csum_d     = 8'h00;
        end else if (xfer) begin
            case (state_q)
                S_HDR0: begin
                    cnt_lo_d = byte_data;
                    state_d  = S_HDR1;
                end
                S_HDR1: begin
                    n_d    = hdr_n;
                    wcnt_d = '0;
                    lane_d = 2'd0;
                    csum_d = 8'h00;
                    if (hdr_n > MAX_N) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else if (hdr_n == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d = csum_q ^ byte_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: wbuf_d[7:0]   = byte_data;
                        2'd1: wbuf_d[15:8]  = byte_data;
                        2'd2: wbuf_d[23:16] = byte_data;
                        default: begin
                            mem_we_d  = 1'b1;
                            wr_addr_d = wcnt_q[ADDR_W-1:0];
                            mem_wd_d  = {byte_data, wbuf_q};
                            wcnt_d    = wcnt_q + 1'b1;
                            if (wcnt_q == n_q - 1'b1) state_d = S_CSUM;
                        end
                    endcase
                end
                S_CSUM: begin
                    if (byte_data == csum_q) begin
                        state_d     = S_RUN;
                        load_done_d = 1'b1;
                        cpu_run_d   = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_lo_q    <= 8'h00;
            n_q         <= '0;
            wcnt_q      <= '0;
            lane_q      <= 2'd0;
            wbuf_q      <= 24'h0;
            csum_q      <= 8'h00;
            mem_we_q    <= 1'b0;
            wr_addr_q   <= '0;
            mem_wd_q    <= 32'h0;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            lane_q      <= lane_d;
            wbuf_q      <= wbuf_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            wr_addr_q   <= wr_addr_d;
            mem_wd_q    <= mem_wd_d;
            cpu_run_q   <= cpu_run_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // In RUN the core's fetch address bypasses the write-address register.
    assign mem_addr  = (state_q == S_RUN) ? cpu_addr : wr_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wd    = mem_wd_q;
    assign cpu_run   = cpu_run_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as frames are driven
// and matched against each mem_we pulse.
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_addr(cpu_addr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && load_done) done_cnt++;
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {22'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {22'h0, mem_addr}, {22'h0, e.addr});
                check("wr_data", mem_wd, e.data);
                $display("write addr=%0d data=0x%08h", mem_addr, mem_wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Sends a frame of n words (n <= 2). stop_after >= 0 aborts after that many data bytes.
    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input bit bad_csum, input int maxgap, input int stop_after);
        logic [31:0] w;
        logic [7:0]  cs;
        logic [7:0]  b;
        int          sent;
        cs   = 8'h00;
        sent = 0;
        send_byte(n[7:0], $urandom_range(maxgap, 0));
        send_byte({5'h0, n[10:8]}, $urandom_range(maxgap, 0));
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int l = 0; l < 4; l++) begin
                if (stop_after >= 0 && sent == stop_after) return;
                b  = w[8*l +: 8];
                cs = cs ^ b;
                if (l == 3) exp_q.push_back('{addr: ADDR_W'(k), data: w});
                send_byte(b, $urandom_range(maxgap, 0));
                sent++;
                if (l == 3) begin
                    check("we_after_lane3", {31'h0, mem_we}, 32'd1);
                    check("addr_after_lane3", {22'h0, mem_addr}, k);
                end
            end
        end
        send_byte(bad_csum ? ~cs : cs, $urandom_range(maxgap, 0));
        check("load_done_edge", {31'h0, load_done}, {31'h0, !bad_csum});
        check("cpu_run_edge", {31'h0, cpu_run}, {31'h0, !bad_csum});
        check("load_err_edge", {31'h0, load_err}, {31'h0, bad_csum});
        $display("frame n=%0d csum=0x%02h bad=%0d done", n, bad_csum ? ~cs : cs, bad_csum);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_byte_ready"}, {31'h0, byte_ready}, 32'd0);
        check({pfx, "_mem_we"}, {31'h0, mem_we}, 32'd0);
        check({pfx, "_mem_addr"}, {22'h0, mem_addr}, 32'd0);
        check({pfx, "_mem_wd"}, mem_wd, 32'd0);
        check({pfx, "_cpu_run"}, {31'h0, cpu_run}, 32'd0);
        check({pfx, "_load_done"}, {31'h0, load_done}, 32'd0);
        check({pfx, "_load_err"}, {31'h0, load_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Good 2-word load
        pulse_load();
        send_frame(2, 32'h0000_0013, 32'hDEAD_BEEF, 1'b0, 0, -1);
        tick();
        check("load_done_pulse", {31'h0, load_done}, 32'd0);
        check("done_count", done_cnt, 32'd1);
        cpu_addr = 10'd5;
        #1;
        check("run_passthru", {22'h0, mem_addr}, 32'd5);
        check("run_no_we", {31'h0, mem_we}, 32'd0);
        check("run_byte_ready", {31'h0, byte_ready}, 32'd0);
        $display("run mem_addr=%0d", mem_addr);

        // Bad checksum
        pulse_load();
        send_frame(2, 32'h0000_0013, 32'hDEAD_BEEF, 1'b1, 0, -1);
        tick();
        check("err_sticky", {31'h0, load_err}, 32'd1);
        check("err_cpu_run", {31'h0, cpu_run}, 32'd0);
        pulse_load();
        check("err_cleared", {31'h0, load_err}, 32'd0);

        // Empty program
        send_frame(0, 32'h0, 32'h0, 1'b0, 0, -1);
        tick();
        check("n0_run", {31'h0, cpu_run}, 32'd1);

        // Oversize header
        pulse_load();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("n1025_err", {31'h0, load_err}, 32'd1);
        check("n1025_not_ready", {31'h0, byte_ready}, 32'd0);
        $display("oversize header rejected load_err=%0d", load_err);

        // 1-word frame with random gaps
        pulse_load();
        send_frame(1, 32'hA5C3_0F71, 32'h0, 1'b0, 5, -1);

        // Reset in the middle of the second word
        pulse_load();
        send_frame(2, 32'h1122_3344, 32'h5566_7788, 1'b0, 0, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_sb_empty", exp_q.size(), 32'd0);
        $display("mid-load reset applied");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_load();
        send_frame(2, 32'hCAFE_F00D, 32'h0BAD_1DEA, 1'b0, 0, -1);

        // Reload from RUN with a byte coincident with load_req
        tick();
        pulse_load();
        check("reload_cpu_run", {31'h0, cpu_run}, 32'd0);
        load_req   = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h7E;
        tick();
        load_req   = 1'b0;
        byte_valid = 1'b0;
        send_frame(1, 32'h0040_0093, 32'h0, 1'b0, 2, -1);

        repeat (3) tick();
        check("final_sb_empty", exp_q.size(), 32'd0);
        check("final_run", {31'h0, cpu_run}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
